// File: rtl/mul_add_pkg.sv
// Shared types and constants for the shift-add multiply-accumulate unit.
package mul_add_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the bit counter (WIDTH >= 2 gives at least 1 bit).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_add_datapath.sv
// Operand shift registers, accumulator and adder for the iterative multiply-accumulate.
module mul_add_datapath
    import mul_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   acc_next_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    areg;
    logic [WIDTH-1:0] breg;
    logic [PW-1:0]    acc;

    // Accumulator value after the current step; the sum never carries out of PW bits.
    always_comb begin
        acc_next_c = acc;
        if (breg[0]) begin
            acc_next_c = acc + areg;
        end
    end

    // Load operands on request, otherwise shift one multiplier bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg <= '0;
            breg <= '0;
            acc  <= '0;
        end else if (load) begin
            areg <= PW'(multiplicand);
            breg <= multiplier;
            acc  <= PW'(addend);
        end else if (step) begin
            acc  <= acc_next_c;
            areg <= areg << 1;
            breg <= breg >> 1;
        end
    end

endmodule

// File: rtl/mul_add.sv
// Sequential product = multiplicand * multiplier + addend with a start/done handshake.
module mul_add
    import mul_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow
);

    localparam int unsigned CNT_W = clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             load;
    logic             step;
    logic             write;
    logic [PW-1:0]    acc_next_c;

    mul_add_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .step         (step),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .acc_next_c   (acc_next_c)
    );

    // Next-state, counter and datapath control; start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        step       = 1'b0;
        write      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                step     = 1'b1;
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    write      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and bit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Registered handshake flags and result, which holds until the next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            done <= (state == DONE);
            if (write) begin
                product  <= acc_next_c;
                overflow <= |acc_next_c[PW-1:WIDTH];
            end
        end
    end

endmodule

// File: doc/mul_add.md
Name: mul_add

Overview:
- Iterative shift-add multiply-accumulate unit that computes product = multiplicand * multiplier + addend.
- It is the inverse companion of the divider: fed quotient, divisor and remainder, it rebuilds the dividend.
- Used in the divider self-check path and as a general sequential multiplier.
- Uses the same start/done handshake as the divider, so one controller drives either block.

Parameters:
- WIDTH, 32, operand width in bits; legal values are >= 2. Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- multiplicand  input  WIDTH  operand A, sampled with start.
- multiplier  input  WIDTH  operand B, sampled with start.
- addend  input  WIDTH  operand C, unsigned, sampled with start.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle completion pulse.
- product  output  2*WIDTH  A*B+C, unsigned.
- overflow  output  1  high when product[2*WIDTH-1:WIDTH] != 0.

Behaviour:
- Reset and clocking:
  - One clock. Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, all registers zero; busy=0, done=0, product=0, overflow=0.
  - Reset asserted mid-operation aborts immediately. No result and no done pulse are produced. After release the block waits for a new start.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at a rising edge latches A into a 2*WIDTH shift register, zero-extended.
  - B is latched into a WIDTH shift register.
  - The accumulator is loaded with C, zero-extended. The bit counter is set to 0.
  - Next state is CALC.
  - start=0 stays in IDLE.
- CALC, once per edge:
  - If B[0]=1, acc += Areg. The add is 2*WIDTH bits wide and cannot carry out.
  - Then Areg <<= 1, B >>= 1, counter += 1.
  - When the counter reaches WIDTH-1 on this edge, the next state is DONE and the final acc is written to product.
  - Fixed WIDTH CALC cycles; there is no early exit, even when B becomes zero.
- DONE:
  - done=1 for exactly one cycle; next state is IDLE.
  - start is ignored in DONE and CALC. A request is never queued.
- Latency:
  - start sampled at edge k gives done=1 in the cycle after edge k+WIDTH+1.
  - That is WIDTH+2 edges from start to done deassertion.
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- Output hold:
  - product and overflow change only on entry to DONE.
  - They hold their value through IDLE until the next result is written.
  - They are not cleared by start.
- Width and wrap rules:
  - All arithmetic is unsigned.
  - The maximum result (2^W-1)^2 + (2^W-1) = 2^2W - 2^W fits in 2*WIDTH bits, so there is no wrap.
  - overflow is registered with product.
- Edge operands:
  - A=0 or B=0 gives product=C, computed after the full latency.
  - Inputs may change freely after the sampling edge.

Decomposition:
- Package mul_add_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Default WIDTH constant.
  - Counter width function clog2(WIDTH).
- Sub-module mul_add_datapath holds the Areg/B shift registers, the accumulator and the adder.
  - Control signals: load, step.
  - The FSM and counter stay in mul_add.

Test Plan:
1. Reset, then start with A=7, B=1, C=3 -> done exactly 34 edges after the start edge; product=10, overflow=0.
2. A=7, B=14, C=2 -> product=100; busy high for 33 cycles; done high for one cycle.
3. A=B=C=32'hFFFFFFFF -> product=64'hFFFFFFFF_00000000, overflow=1.
4. A=0, B=150, C=70 -> product=70 after full latency. Then A=100, B=0, C=0 -> product=0, and the previous product is held until that done.
5. start pulsed again at 10 cycles into CALC and in the DONE cycle -> ignored; exactly one done; product equals the first request's result.
6. rst_n driven low 5 cycles into CALC, asynchronously between edges -> outputs zero immediately; no done. A new start with A=100, B=1, C=0 -> product=100.
